// File: rtl/main_pkg.sv
// main_pkg: opcode/funct/ALU encodings, decode control bundle and
// instruction encoders used to build the boot program.
package main_pkg;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;
    localparam int PROG_WORDS = 16;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    typedef struct packed {
        logic    reg_we;
        logic    mem_we;
        logic    use_imm;
        logic    is_lw;
        logic    is_beq;
        logic    is_jal;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_SW};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BR};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    function automatic logic [PROG_WORDS*32-1:0] default_prog();
        logic [PROG_WORDS*32-1:0] p;
        p = '0;
        p[0*32 +: 32] = enc_i(12'd5, 5'd0, F3_ADD, 5'd1, OP_I);
        p[1*32 +: 32] = enc_i(12'd7, 5'd0, F3_ADD, 5'd3, OP_I);
        p[2*32 +: 32] = enc_r(F7_BASE, 5'd3, 5'd1, F3_ADD, 5'd4);
        p[3*32 +: 32] = enc_s(12'd64, 5'd4, 5'd0);
        p[4*32 +: 32] = enc_i(12'd64, 5'd0, F3_LW, 5'd1, OP_LW);
        p[5*32 +: 32] = enc_b(13'd8, 5'd4, 5'd1);
        p[6*32 +: 32] = enc_i(12'd99, 5'd0, F3_ADD, 5'd3, OP_I);
        p[7*32 +: 32] = enc_i(12'd1, 5'd3, F3_ADD, 5'd3, OP_I);
        p[8*32 +: 32] = enc_j(21'd0, 5'd0);
        return p;
    endfunction
endpackage

// File: rtl/main_if.sv
// main_if: data-memory bus between the core datapath and its RAM.
interface main_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/main_dmem.sv
// main_dmem: word-addressed data RAM, async read, write on rising edge, cleared by reset.
module main_dmem #(
    parameter int DMEM_WORDS = 64
) (
    input logic   clk,
    input logic   rst,
    main_if.slave bus
);
    localparam int AW = $clog2(DMEM_WORDS);
    logic [31:0] d_mem [0:DMEM_WORDS-1];
    logic [31:0] wa;
    logic [AW-1:0] idx;

    // byte offset dropped by the shift; index wraps onto the RAM depth
    assign wa = bus.addr >> 2;
    assign idx = AW'(wa % 32'(DMEM_WORDS));
    assign bus.rdata = d_mem[idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DMEM_WORDS; i++) d_mem[i] <= '0;
        end else if (bus.we) begin
            d_mem[idx] <= bus.wdata;
        end
    end
endmodule

// File: rtl/main_regs.sv
// main_regs: 32x32 register file, two async read ports, one write port; x0 never written.
module main_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic        we_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] reg_num [0:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) reg_num[i] <= '0;
        end else if (we_i && rd_i != 5'd0) begin
            reg_num[rd_i] <= wd_i;
        end
    end

    assign rd1_o = reg_num[rs1_i];
    assign rd2_o = reg_num[rs2_i];
endmodule

// File: rtl/main.sv
// main: single-cycle RV32I-subset core (ADD SUB AND OR SLT ADDI LW SW BEQ JAL);
// anything else retires as a NOP.
module main
    import main_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64,
    parameter logic [PROG_WORDS*32-1:0] PROG = default_prog()
) (
    input logic rst,
    input logic clk
);
    localparam int IAW = $clog2(IMEM_WORDS);
    logic [31:0] rom [IMEM_WORDS];
    logic [31:0] pc_q, pc_d, pc4, iw, instr, imm, rs1_v, rs2_v, alu_b, alu_y, wd;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic [IAW-1:0] iidx;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    ctrl_t c;
    main_if dbus ();

    for (genvar g = 0; g < IMEM_WORDS; g++) begin : g_rom
        if (g < PROG_WORDS) begin : g_p
            assign rom[g] = PROG[g*32 +: 32];
        end else begin : g_z
            assign rom[g] = '0;
        end
    end

    assign iw    = pc_q >> 2;
    assign iidx  = IAW'(iw % 32'(IMEM_WORDS));
    assign instr = rom[iidx];
    assign opc   = instr[6:0];
    assign f3    = instr[14:12];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        c = '0;
        c.alu_op = ALU_ADD;
        imm = '0;
        case (opc)
            OP_R: begin
                c.reg_we = (f7 == F7_BASE && f3 inside {F3_ADD, F3_SLT, F3_OR, F3_AND})
                        || (f7 == F7_SUB && f3 == F3_ADD);
                c.alu_op = f7 == F7_SUB ? ALU_SUB : f3 == F3_SLT ? ALU_SLT :
                           f3 == F3_OR ? ALU_OR : f3 == F3_AND ? ALU_AND : ALU_ADD;
            end
            OP_I: begin
                c.reg_we = f3 == F3_ADD;
                c.use_imm = 1'b1;
                imm = imm_i;
            end
            OP_LW: begin
                c.reg_we = f3 == F3_LW;
                c.is_lw = f3 == F3_LW;
                c.use_imm = 1'b1;
                imm = imm_i;
            end
            OP_SW: begin
                c.mem_we = f3 == F3_SW;
                c.use_imm = 1'b1;
                imm = imm_s;
            end
            OP_BR: begin
                c.is_beq = f3 == F3_BEQ;
                imm = imm_b;
            end
            OP_JAL: begin
                c.reg_we = 1'b1;
                c.is_jal = 1'b1;
                imm = imm_j;
            end
            default: ;
        endcase
    end

    assign alu_b = c.use_imm ? imm : rs2_v;
    assign alu_y = c.alu_op == ALU_SUB ? rs1_v - alu_b :
                   c.alu_op == ALU_AND ? rs1_v & alu_b :
                   c.alu_op == ALU_OR  ? rs1_v | alu_b :
                   c.alu_op == ALU_SLT ? {31'b0, $signed(rs1_v) < $signed(alu_b)} :
                   rs1_v + alu_b;

    assign pc4  = pc_q + 32'd4;
    assign pc_d = (c.is_jal || (c.is_beq && rs1_v == rs2_v)) ? pc_q + imm : pc4;
    assign wd   = c.is_jal ? pc4 : c.is_lw ? dbus.rdata : alu_y;

    assign dbus.we    = c.mem_we;
    assign dbus.addr  = alu_y;
    assign dbus.wdata = rs2_v;

    main_regs regs (
        .clk   (clk),
        .rst   (rst),
        .rs1_i (instr[19:15]),
        .rs2_i (instr[24:20]),
        .rd_i  (instr[11:7]),
        .we_i  (c.reg_we),
        .wd_i  (wd),
        .rd1_o (rs1_v),
        .rd2_o (rs2_v)
    );

    main_dmem #(.DMEM_WORDS(DMEM_WORDS)) D_mem (
        .clk (clk),
        .rst (rst),
        .bus (dbus)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_q <= '0;
        else pc_q <= pc_d;
    end
endmodule

// File: tb/tb_main.sv
// tb_main: three core instances (boot program, ALU/branch program, x0/NOP program)
// checked edge by edge against an instruction-level interpreter, with random async resets.
module tb_main;
    import main_pkg::*;

    function automatic logic [PROG_WORDS*32-1:0] prog_alu();
        logic [PROG_WORDS*32-1:0] p;
        p = '0;
        p[0*32 +: 32]  = enc_i(12'hFF9, 5'd0, F3_ADD, 5'd1, OP_I);
        p[1*32 +: 32]  = enc_i(12'd3, 5'd0, F3_ADD, 5'd2, OP_I);
        p[2*32 +: 32]  = enc_r(F7_SUB, 5'd1, 5'd2, F3_ADD, 5'd3);
        p[3*32 +: 32]  = enc_r(F7_BASE, 5'd2, 5'd1, F3_SLT, 5'd4);
        p[4*32 +: 32]  = enc_r(F7_BASE, 5'd1, 5'd2, F3_SLT, 5'd5);
        p[5*32 +: 32]  = enc_r(F7_BASE, 5'd2, 5'd1, F3_AND, 5'd6);
        p[6*32 +: 32]  = enc_r(F7_BASE, 5'd2, 5'd1, F3_OR, 5'd7);
        p[7*32 +: 32]  = enc_s(12'd262, 5'd3, 5'd0);
        p[8*32 +: 32]  = enc_i(12'd4, 5'd0, F3_LW, 5'd8, OP_LW);
        p[9*32 +: 32]  = enc_b(13'd8, 5'd2, 5'd1);
        p[10*32 +: 32] = enc_j(21'd8, 5'd9);
        p[11*32 +: 32] = enc_i(12'd1, 5'd0, F3_ADD, 5'd10, OP_I);
        p[12*32 +: 32] = enc_r(F7_BASE, 5'd1, 5'd1, F3_ADD, 5'd11);
        p[13*32 +: 32] = enc_j(21'd0, 5'd0);
        return p;
    endfunction

    function automatic logic [PROG_WORDS*32-1:0] prog_x0();
        logic [PROG_WORDS*32-1:0] p;
        p = '0;
        p[0*32 +: 32] = enc_i(12'd9, 5'd0, F3_ADD, 5'd0, OP_I);
        p[1*32 +: 32] = 32'h0000007F;
        p[2*32 +: 32] = enc_i(12'd3, 5'd0, F3_ADD, 5'd5, OP_I);
        p[3*32 +: 32] = enc_r(7'h01, 5'd5, 5'd5, F3_ADD, 5'd6);
        p[4*32 +: 32] = enc_j(21'd0, 5'd0);
        return p;
    endfunction

    localparam logic [PROG_WORDS*32-1:0] P0 = default_prog();
    localparam logic [PROG_WORDS*32-1:0] P1 = prog_alu();
    localparam logic [PROG_WORDS*32-1:0] P2 = prog_x0();

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_err = 0;
    int n_chk = 0;
    always #5 clk = ~clk;

    main u_dut (.rst(rst), .clk(clk));
    main #(.PROG(P1)) u_alu (.rst(rst), .clk(clk));
    main #(.PROG(P2)) u_x0 (.rst(rst), .clk(clk));

    main_if mon ();
    assign mon.we    = u_dut.dbus.we;
    assign mon.addr  = u_dut.dbus.addr;
    assign mon.wdata = u_dut.dbus.wdata;
    assign mon.rdata = u_dut.dbus.rdata;

    logic [31:0] o_pc [3];
    logic [31:0] o_rf [3][32];
    logic [31:0] o_dm [3][64];
    always_comb begin
        o_pc[0] = u_dut.pc_q;
        o_pc[1] = u_alu.pc_q;
        o_pc[2] = u_x0.pc_q;
        for (int i = 0; i < 32; i++) begin
            o_rf[0][i] = u_dut.regs.reg_num[i];
            o_rf[1][i] = u_alu.regs.reg_num[i];
            o_rf[2][i] = u_x0.regs.reg_num[i];
        end
        for (int i = 0; i < 64; i++) begin
            o_dm[0][i] = u_dut.D_mem.d_mem[i];
            o_dm[1][i] = u_alu.D_mem.d_mem[i];
            o_dm[2][i] = u_x0.D_mem.d_mem[i];
        end
    end

    logic [31:0] m_prog [3][16];
    logic [31:0] m_pc [3];
    logic [31:0] m_rf [3][32];
    logic [31:0] m_dm [3][64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_pc[k] = '0;
            for (int i = 0; i < 32; i++) m_rf[k][i] = '0;
            for (int i = 0; i < 64; i++) m_dm[k][i] = '0;
        end
    endtask

    // ISA-level interpreter: one architectural instruction per call
    task automatic m_step(input int k);
        logic [31:0] ins, pc, a, b, r, np, ii, is, ib, ij;
        logic wr;
        int ia;
        pc = m_pc[k];
        ia = int'((pc >> 2) % 64);
        ins = ia < 16 ? m_prog[k][ia] : 32'h0;
        a = m_rf[k][ins[19:15]];
        b = m_rf[k][ins[24:20]];
        ii = 32'($signed(ins[31:20]));
        is = 32'($signed({ins[31:25], ins[11:7]}));
        ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        np = pc + 4;
        wr = 1'b0;
        r = '0;
        case (ins[6:0])
            7'h33: case ({ins[31:25], ins[14:12]})
                10'h000: begin r = a + b; wr = 1'b1; end
                10'h100: begin r = a - b; wr = 1'b1; end
                10'h002: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; wr = 1'b1; end
                10'h006: begin r = a | b; wr = 1'b1; end
                10'h007: begin r = a & b; wr = 1'b1; end
                default: ;
            endcase
            7'h13: if (ins[14:12] == 3'd0) begin r = a + ii; wr = 1'b1; end
            7'h03: if (ins[14:12] == 3'd2) begin r = m_dm[k][((a + ii) >> 2) % 64]; wr = 1'b1; end
            7'h23: if (ins[14:12] == 3'd2) m_dm[k][((a + is) >> 2) % 64] = b;
            7'h63: if (ins[14:12] == 3'd0 && a == b) np = pc + ib;
            7'h6f: begin r = pc + 4; wr = 1'b1; np = pc + ij; end
            default: ;
        endcase
        if (wr && ins[11:7] != 5'd0) m_rf[k][ins[11:7]] = r;
        m_pc[k] = np;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d pc", k), o_pc[k], m_pc[k]);
            for (int i = 0; i < 32; i++) check($sformatf("u%0d x%0d", k, i), o_rf[k][i], m_rf[k][i]);
            for (int i = 0; i < 64; i++) check($sformatf("u%0d mem%0d", k, i), o_dm[k][i], m_dm[k][i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 3; k++) m_step(k);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_prog[0][i] = P0[i*32 +: 32];
            m_prog[1][i] = P1[i*32 +: 32];
            m_prog[2][i] = P2[i*32 +: 32];
        end
        m_reset();
        #2 rst = 1'b0;
        #1 compare_all();
        check("reset pc", o_pc[0], 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step();
            check($sformatf("e%0d x0", e), o_rf[0][0], 32'd0);
            if (e == 1) check("e1 x1", o_rf[0][1], 32'd5);
            if (e == 2) check("e2 x3", o_rf[0][3], 32'd7);
            if (e == 3) begin
                check("e3 x4", o_rf[0][4], 32'd12);
                check("sw we", {31'b0, mon.we}, 32'd1);
                check("sw addr", mon.addr, 32'd64);
                check("sw wdata", mon.wdata, 32'd12);
            end
            if (e == 4) check("e4 mem16", o_dm[0][16], 32'd12);
            if (e == 5) check("e5 x1", o_rf[0][1], 32'd12);
            if (e == 6) check("e6 pc", o_pc[0], 32'd28);
            if (e == 6) check("e6 x3", o_rf[0][3], 32'd7);
            if (e == 7) check("e7 x3", o_rf[0][3], 32'd8);
            if (e >= 8) begin
                check("halt pc", o_pc[0], 32'd32);
                check("halt x1", o_rf[0][1], 32'd12);
                check("halt x3", o_rf[0][3], 32'd8);
                check("halt x4", o_rf[0][4], 32'd12);
                check("halt mem16", o_dm[0][16], 32'd12);
            end
        end
        check("alu sub", o_rf[1][3], 32'd10);
        check("alu slt t", o_rf[1][4], 32'd1);
        check("alu slt f", o_rf[1][5], 32'd0);
        check("alu and", o_rf[1][6], 32'd1);
        check("alu or", o_rf[1][7], 32'hFFFF_FFFB);
        check("alu lw", o_rf[1][8], 32'd10);
        check("alu link", o_rf[1][9], 32'd44);
        check("alu skip", o_rf[1][10], 32'd0);
        check("alu add neg", o_rf[1][11], 32'hFFFF_FFF2);
        check("alu memwrap", o_dm[1][1], 32'd10);
        check("alu pc", o_pc[1], 32'd52);
        check("x0 pc", o_pc[2], 32'd16);
        check("x0 r0", o_rf[2][0], 32'd0);
        check("x0 r5", o_rf[2][5], 32'd3);
        check("x0 r6", o_rf[2][6], 32'd0);

        rst = 1'b0;
        m_reset();
        #1 compare_all();
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        #2 rst = 1'b0;
        m_reset();
        #1;
        check("mid rst pc", o_pc[0], 32'd0);
        check("mid rst x1", o_rf[0][1], 32'd0);
        check("mid rst x4", o_rf[0][4], 32'd0);
        check("mid rst mem16", o_dm[0][16], 32'd0);
        compare_all();
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 10; e++) step();
        check("rerun pc", o_pc[0], 32'd32);
        check("rerun x1", o_rf[0][1], 32'd12);
        check("rerun x3", o_rf[0][3], 32'd8);
        check("rerun x4", o_rf[0][4], 32'd12);
        check("rerun mem16", o_dm[0][16], 32'd12);

        for (int t = 0; t < 10; t++) begin
            int n = int'($urandom_range(0, 18));
            for (int e = 0; e < n; e++) step();
            #($urandom_range(1, 3));
            rst = 1'b0;
            m_reset();
            #1 compare_all();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
        end
        for (int e = 0; e < 14; e++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/main.md
MAIN -- requirements
Module: main

Interface
REQ-001 Parameter IMEM_WORDS, default 64, instruction ROM depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 64, data RAM depth in 32-bit words.
REQ-003 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset (rst=0 resets).
REQ-005 Positional port order SHALL be (rst, clk); the block has no other ports and is observed only through its hierarchy.

Function
REQ-006 The block SHALL be a single-cycle RV32I-subset core that completes one instruction per rising clk edge while rst=1.
REQ-007 Supported instructions SHALL be ADD, SUB, AND, OR, SLT, ADDI, LW, SW, BEQ and JAL, with standard RV32I encodings and sign-extended immediates.
REQ-008 Any other opcode or funct combination SHALL execute as a NOP: PC+4, no register write, no memory write.
REQ-009 PC SHALL be 32 bits; next PC SHALL be PC+4, PC+imm for taken BEQ, or PC+imm for JAL; JAL SHALL write PC+4 to rd.
REQ-010 Instruction fetch SHALL be combinational from ROM word PC[31:2] modulo IMEM_WORDS.
REQ-011 Register file SHALL hold 32 x 32-bit registers with two combinational read ports and one write port written on the rising edge.
REQ-012 Writes to x0 SHALL be discarded; x0 SHALL always read 0.
REQ-013 Data RAM SHALL be word-addressed by ALU result [31:2] modulo DMEM_WORDS; byte offset bits [1:0] SHALL be ignored.
REQ-014 LW SHALL read combinationally; SW SHALL write on the rising edge; no byte/half accesses.
REQ-015 SLT SHALL be a signed compare; all arithmetic SHALL wrap modulo 2^32 with no exceptions.
REQ-016 A read of a register written by the same instruction SHALL return the old value.
REQ-017 The ROM SHALL be preloaded at word indices 0..8 with: addi x1,x0,5; addi x3,x0,7; add x4,x1,x3; sw x4,64(x0); lw x1,64(x0); beq x1,x4,+8; addi x3,x0,99; addi x3,x3,1; jal x0,0. All other ROM words SHALL be 0 (NOP).

Reset
REQ-018 While rst=0, PC SHALL be 0, all 32 registers 0 and all data RAM words 0, asynchronously.
REQ-019 The first instruction after rst deasserts SHALL execute on the first rising edge with rst=1.
REQ-020 Assertion of rst mid-program SHALL abort immediately; execution SHALL restart from PC 0 with cleared state.

Structure
REQ-021 Opcode, funct3/funct7 and ALU-operation encodings SHALL be constants in a shared package.
REQ-022 The register file SHALL be a sub-module instantiated as regs with storage array reg_num[0:31].
REQ-023 Data memory SHALL be a sub-module instantiated as D_mem with storage array d_mem[0:DMEM_WORDS-1].
REQ-024 ALU, immediate generation and control decode SHALL be inside main; a single alu sub-module is permitted.

Verification
REQ-025 Reset then release: after rising edges 1/2/3 -> reg_num[1]=5, reg_num[3]=7, reg_num[4]=12; reg_num[0]=0 throughout.
REQ-026 Store/load: after edge 4 -> d_mem[16]=12; after edge 5 -> reg_num[1]=12.
REQ-027 Branch taken: edge 6 -> PC=28, instruction 6 skipped; edge 7 -> reg_num[3]=8, never 99.
REQ-028 Halt loop: edges 8-10 -> PC stays 32, all observed values unchanged (r1=12, r3=8, r4=12, mem16=12).
REQ-029 Asynchronous reset between edges 5 and 6: drive rst=0 -> PC, registers and d_mem[16] read 0 immediately; on release the program reruns to identical results.
REQ-030 x0 protection: load ROM with addi x0,x0,9 -> reg_num[0] stays 0; unsupported opcode 0x7F -> no state change except PC+4.
